// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage response unit: FSM states, access sizes,
// latched load controls and the discard-counter width helper.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef struct packed {
    logic       load;
    logic       sign;
    logic [1:0] size;
  } ld_ctrl_t;

  function automatic int unsigned cnt_w(input int unsigned max_discard);
    return $clog2(max_discard + 1);
  endfunction

endpackage

// File: rtl/mem_resp_stage_if.sv
// EX offer, data-cache response, flush and WB handshake bundle of the MEM stage.
interface mem_resp_stage_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PAYLOAD_W = 160
);
  localparam int unsigned OFS_W = $clog2(DATA_W / 8);

  logic                 ex_to_mem_valid_i;
  logic                 mem_allowin_o;
  logic                 ex_req_i;
  logic                 ex_load_i;
  logic [1:0]           ex_size_i;
  logic                 ex_sign_i;
  logic [OFS_W-1:0]     ex_ofs_i;
  logic [DATA_W-1:0]    ex_result_i;
  logic [PAYLOAD_W-1:0] ex_payload_i;
  logic                 data_ok_i;
  logic [DATA_W-1:0]    rdata_i;
  logic                 excep_flush_i;
  logic                 wb_allowin_i;
  logic                 mem_to_wb_valid_o;
  logic [DATA_W-1:0]    wb_result_o;
  logic [PAYLOAD_W-1:0] wb_payload_o;
  logic                 dr_stall_o;

  modport master (
    output ex_to_mem_valid_i, ex_req_i, ex_load_i, ex_size_i, ex_sign_i, ex_ofs_i,
           ex_result_i, ex_payload_i, data_ok_i, rdata_i, excep_flush_i, wb_allowin_i,
    input  mem_allowin_o, mem_to_wb_valid_o, wb_result_o, wb_payload_o, dr_stall_o
  );

  modport slave (
    input  ex_to_mem_valid_i, ex_req_i, ex_load_i, ex_size_i, ex_sign_i, ex_ofs_i,
           ex_result_i, ex_payload_i, data_ok_i, rdata_i, excep_flush_i, wb_allowin_i,
    output mem_allowin_o, mem_to_wb_valid_o, wb_result_o, wb_payload_o, dr_stall_o
  );

endinterface

// File: rtl/mem_load_ext.sv
// Combinational load aligner: shift by byte offset, mask to access size, then
// sign- or zero-extend to the full data width.
module mem_load_ext import mem_pkg::*; #(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned OFS_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [OFS_W-1:0]  ofs,
  output logic [DATA_W-1:0] res
);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  logic [1:0]        eff_size;
  logic [IDX_W-1:0]  msb;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              fill;

  // A dword request on a 32-bit bus degrades to a word access.
  always_comb begin
    eff_size = (DATA_W == 32 && size == SZ_D) ? SZ_W : size;
    msb      = IDX_W'((32'd8 << eff_size) - 32'd1);
    shifted  = data >> {ofs, 3'b000};
    mask     = ~(({DATA_W{1'b1}} << msb) << 1);
    fill     = sign & shifted[msb];
    res      = (shifted & mask) | ({DATA_W{fill}} & ~mask);
  end

endmodule

// File: rtl/mem_resp_stage.sv
// MEM-stage response unit: owns the stage register, tracks one outstanding
// cache access, holds results under WB back-pressure and drops orphaned responses.
module mem_resp_stage import mem_pkg::*; #(
  parameter  int unsigned DATA_W      = 32,
  parameter  int unsigned PAYLOAD_W   = 160,
  parameter  int unsigned MAX_DISCARD = 3,
  localparam int unsigned OFS_W       = $clog2(DATA_W / 8),
  localparam int unsigned CNT_W       = cnt_w(MAX_DISCARD)
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_resp_stage_if.slave  bus,
  output logic [CNT_W-1:0] discard_cnt_o
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  ld_ctrl_t             ctrl_q;
  logic [OFS_W-1:0]     ofs_q;
  logic [DATA_W-1:0]    res_q;
  logic [PAYLOAD_W-1:0] pay_q;

  logic              rsp_own, rsp_drop, flush, valid, allowin, entry, capture;
  logic [DATA_W-1:0] ld_val, own_val;

  mem_load_ext #(.DATA_W(DATA_W)) u_ext (
    .data (bus.rdata_i),
    .size (ctrl_q.size),
    .sign (ctrl_q.sign),
    .ofs  (ofs_q),
    .res  (ld_val)
  );

  // Responses arriving while orphans are pending belong to flushed requests.
  assign rsp_own  = bus.data_ok_i & (cnt_q == '0);
  assign rsp_drop = bus.data_ok_i & (cnt_q != '0);
  assign flush    = bus.excep_flush_i;
  assign valid    = ~flush & ((state_q == ST_HOLD) | ((state_q == ST_WAIT) & rsp_own));
  assign allowin  = ((state_q == ST_EMPTY) | (valid & bus.wb_allowin_i))
                    & (cnt_q < CNT_W'(MAX_DISCARD));
  assign entry    = bus.ex_to_mem_valid_i & allowin & ~flush;
  assign own_val  = ctrl_q.load ? ld_val : res_q;

  assign bus.mem_allowin_o     = allowin;
  assign bus.mem_to_wb_valid_o = valid;
  assign bus.wb_result_o       = ((state_q == ST_WAIT) & rsp_own) ? own_val : res_q;
  assign bus.wb_payload_o      = pay_q;
  assign bus.dr_stall_o        = (state_q == ST_WAIT) & ctrl_q.load & ~rsp_own;
  assign discard_cnt_o         = cnt_q;

  // Next state, capture strobe and orphan accounting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: state_d = ST_EMPTY;
        ST_WAIT: begin
          if (rsp_own) begin
            state_d = bus.wb_allowin_i ? ST_EMPTY : ST_HOLD;
            capture = ~bus.wb_allowin_i;
          end
        end
        ST_HOLD: if (bus.wb_allowin_i) state_d = ST_EMPTY;
        default: state_d = ST_EMPTY;
      endcase
      if (entry) state_d = bus.ex_req_i ? ST_WAIT : ST_HOLD;
    end
    if (flush && state_q == ST_WAIT && !rsp_own) cnt_d = cnt_d + CNT_W'(1);
    if (rsp_drop)                                cnt_d = cnt_d - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      ofs_q   <= '0;
      res_q   <= '0;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (entry) begin
        ctrl_q <= '{load: bus.ex_load_i, sign: bus.ex_sign_i, size: bus.ex_size_i};
        ofs_q  <= bus.ex_ofs_i;
        res_q  <= bus.ex_result_i;
        pay_q  <= bus.ex_payload_i;
      end else if (capture) begin
        res_q  <= own_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_resp_stage.sv
// Bench for mem_resp_stage: a 32-bit/MAX_DISCARD=2 instance checked against a
// transaction-level model, plus a 64-bit instance for wide load extension.
module tb_mem_resp_stage;
  import mem_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] cnt32, cnt64;

  int checks = 0;
  int errors = 0;

  mem_resp_stage_if #(.DATA_W(32), .PAYLOAD_W(32)) b32 ();
  mem_resp_stage_if #(.DATA_W(64), .PAYLOAD_W(32)) b64 ();

  mem_resp_stage #(.DATA_W(32), .PAYLOAD_W(32), .MAX_DISCARD(2)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(b32), .discard_cnt_o(cnt32));
  mem_resp_stage #(.DATA_W(64), .PAYLOAD_W(32), .MAX_DISCARD(3)) u64 (
    .clk(clk), .rst_n(rst_n), .bus(b64), .discard_cnt_o(cnt64));

  always #5 clk = ~clk;

  // Model of the 32-bit instance: slot contents plus count of orphaned requests.
  bit          m_full, m_pend, m_load, m_sign;
  int          m_size, m_ofs, m_orph;
  logic [31:0] m_res, m_pay;

  typedef struct {
    bit          w64;
    logic [1:0]  size;
    bit          sign;
    int          ofs;
    logic [63:0] rdata;
    logic [63:0] exp;
  } vec_t;
  localparam int NV = 12;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_ext(input logic [63:0] data, input int dw,
                                          input int size, input bit sign, input int ofs);
    int          sz;
    int          bits;
    logic [63:0] v;
    logic [63:0] half;
    sz   = (dw == 32 && size == 3) ? 2 : size;
    bits = 8 << sz;
    v    = data >> (8 * ofs);
    half = 64'd1 << (bits - 1);
    if (bits < 64) v = v % (half << 1);
    if (sign && v >= half) v = v - (half << 1);
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic drv32(input bit v, input bit req, input bit ld, input logic [1:0] sz,
                       input bit sg, input logic [1:0] of, input logic [31:0] res,
                       input bit dok, input logic [31:0] rd, input bit fl, input bit wa);
    b32.ex_to_mem_valid_i = v;   b32.ex_req_i = req;  b32.ex_load_i = ld;
    b32.ex_size_i = sz;          b32.ex_sign_i = sg;  b32.ex_ofs_i = of;
    b32.ex_result_i = res;       b32.ex_payload_i = $urandom;
    b32.data_ok_i = dok;         b32.rdata_i = rd;
    b32.excep_flush_i = fl;      b32.wb_allowin_i = wa;
  endtask

  task automatic idle64();
    b64.ex_to_mem_valid_i = 0; b64.ex_req_i = 0; b64.ex_load_i = 0; b64.ex_size_i = 0;
    b64.ex_sign_i = 0; b64.ex_ofs_i = 0; b64.ex_result_i = 0; b64.ex_payload_i = 0;
    b64.data_ok_i = 0; b64.rdata_i = 0; b64.excep_flush_i = 0; b64.wb_allowin_i = 1;
  endtask

  // Called at a falling edge with inputs already driven; compares, then advances one cycle.
  task automatic tick32();
    bit          own, ev, ea, es, entry, drop;
    logic [63:0] ext;
    logic [31:0] er;
    #1;
    if (!rst_n) begin
      m_full = 0; m_pend = 0; m_orph = 0; m_res = '0; m_pay = '0;
      chk("rst_valid",   b32.mem_to_wb_valid_o, 0);
      chk("rst_allowin", b32.mem_allowin_o, 1);
      chk("rst_stall",   b32.dr_stall_o, 0);
      chk("rst_result",  b32.wb_result_o, 0);
      chk("rst_payload", b32.wb_payload_o, 0);
      chk("rst_cnt",     cnt32, 0);
      @(posedge clk);
      @(negedge clk);
      return;
    end
    own = b32.data_ok_i && m_orph == 0;
    ev  = !b32.excep_flush_i && m_full && (!m_pend || own);
    ext = ref_ext({32'b0, b32.rdata_i}, 32, m_size, m_sign, m_ofs);
    er  = (m_pend && m_load) ? ext[31:0] : m_res;
    ea  = (!m_full || (ev && b32.wb_allowin_i)) && m_orph < 2;
    es  = m_full && m_pend && m_load && !own;
    chk("valid",   b32.mem_to_wb_valid_o, 64'(ev));
    chk("allowin", b32.mem_allowin_o, 64'(ea));
    chk("stall",   b32.dr_stall_o, 64'(es));
    chk("cnt",     cnt32, 64'(m_orph));
    if (ev) begin
      chk("result",  b32.wb_result_o, er);
      chk("payload", b32.wb_payload_o, m_pay);
    end
    entry = b32.ex_to_mem_valid_i && ea && !b32.excep_flush_i;
    drop  = b32.data_ok_i && m_orph != 0;
    @(posedge clk);
    if (b32.excep_flush_i) begin
      if (m_full && m_pend && !own) m_orph++;
      m_full = 0;
    end else begin
      if (m_full && m_pend && own) begin m_pend = 0; m_res = er; end
      if (ev && b32.wb_allowin_i) m_full = 0;
      if (entry) begin
        m_full = 1;                  m_pend = b32.ex_req_i;
        m_load = b32.ex_load_i;      m_sign = b32.ex_sign_i;
        m_size = int'(b32.ex_size_i); m_ofs = int'(b32.ex_ofs_i);
        m_res  = b32.ex_result_i;    m_pay  = b32.ex_payload_i;
      end
    end
    if (drop) m_orph--;
    @(negedge clk);
  endtask

  initial begin
    vec[0]  = '{0, SZ_B, 1, 2, 64'h12803456,         64'hFFFFFF80};
    vec[1]  = '{0, SZ_B, 0, 2, 64'h12803456,         64'h00000080};
    vec[2]  = '{0, SZ_H, 1, 2, 64'h80013456,         64'hFFFF8001};
    vec[3]  = '{0, SZ_H, 0, 0, 64'h1234F00D,         64'h0000F00D};
    vec[4]  = '{0, SZ_W, 1, 0, 64'hDEADBEEF,         64'hDEADBEEF};
    vec[5]  = '{0, SZ_D, 1, 0, 64'h87654321,         64'h87654321};
    vec[6]  = '{0, SZ_B, 1, 3, 64'h7F000000,         64'h0000007F};
    vec[7]  = '{1, SZ_D, 0, 0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    vec[8]  = '{1, SZ_H, 0, 6, 64'h0123456789ABCDEF, 64'h0000000000000123};
    vec[9]  = '{1, SZ_W, 1, 4, 64'h89ABCDEF00000000, 64'hFFFFFFFF89ABCDEF};
    vec[10] = '{1, SZ_B, 1, 7, 64'hFE00000000000000, 64'hFFFFFFFFFFFFFFFE};
    vec[11] = '{1, SZ_W, 0, 4, 64'h89ABCDEF00000000, 64'h0000000089ABCDEF};

    clk = 0; rst_n = 0;
    drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle64();
    @(negedge clk);
    #1;
    chk("rst64_valid",   b64.mem_to_wb_valid_o, 0);
    chk("rst64_allowin", b64.mem_allowin_o, 1);
    chk("rst64_cnt",     cnt64, 0);
    tick32(); tick32();
    rst_n = 1;
    tick32();

    // Load-extension table: entry cycle, then data_ok with WB ready.
    for (int i = 0; i < NV; i++) begin
      if (!vec[i].w64) begin
        drv32(1, 1, 1, vec[i].size, vec[i].sign, 2'(vec[i].ofs), $urandom, 0, 0, 0, 1);
        tick32();
        drv32(0, 0, 0, 0, 0, 0, 0, 1, vec[i].rdata[31:0], 0, 1);
        #1;
        chk("ext32_valid", b32.mem_to_wb_valid_o, 1);
        chk("ext32", b32.wb_result_o, vec[i].exp);
        tick32();
        drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      end else begin
        b64.ex_to_mem_valid_i = 1; b64.ex_req_i = 1; b64.ex_load_i = 1;
        b64.ex_size_i = vec[i].size; b64.ex_sign_i = vec[i].sign;
        b64.ex_ofs_i = 3'(vec[i].ofs); b64.ex_payload_i = 32'(i);
        #1;
        chk("ext64_allowin", b64.mem_allowin_o, 1);
        @(posedge clk); @(negedge clk);
        b64.ex_to_mem_valid_i = 0; b64.data_ok_i = 1; b64.rdata_i = vec[i].rdata;
        #1;
        chk("ext64_valid", b64.mem_to_wb_valid_o, 1);
        chk("ext64", b64.wb_result_o, vec[i].exp);
        chk("ext64_payload", b64.wb_payload_o, 64'(i));
        @(posedge clk); @(negedge clk);
        idle64();
      end
    end

    // Back-pressure: result and valid hold for three WB stall cycles.
    drv32(1, 1, 1, SZ_W, 0, 0, 0, 0, 0, 0, 1); tick32();
    drv32(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    #1; chk("bp_first", b32.wb_result_o, 64'hDEADBEEF); tick32();
    for (int k = 0; k < 3; k++) begin
      drv32(1, 1, 1, SZ_W, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("bp_hold_valid",   b32.mem_to_wb_valid_o, 1);
      chk("bp_hold_result",  b32.wb_result_o, 64'hDEADBEEF);
      chk("bp_hold_allowin", b32.mem_allowin_o, 0);
      tick32();
    end
    drv32(1, 0, 0, SZ_W, 0, 0, 32'h55, 0, 0, 0, 1);
    #1; chk("bp_take_allowin", b32.mem_allowin_o, 1); tick32();
    drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1; chk("nonmem_latency", b32.wb_result_o, 64'h55); tick32();
    tick32();

    // Flush in WAIT, new load enters, first response dropped, second owned.
    drv32(1, 1, 1, SZ_W, 0, 0, 0, 0, 0, 0, 1); tick32();
    drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);    tick32();
    drv32(1, 1, 1, SZ_W, 0, 0, 0, 0, 0, 0, 1);
    #1; chk("fl_cnt1", cnt32, 1); tick32();
    drv32(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111, 0, 1);
    #1; chk("fl_drop_valid", b32.mem_to_wb_valid_o, 0); tick32();
    drv32(0, 0, 0, 0, 0, 0, 0, 1, 32'h2222, 0, 1);
    #1; chk("fl_own_result", b32.wb_result_o, 64'h2222); tick32();
    drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick32();

    // Discard limit: two orphans block entry until one response drains.
    for (int k = 0; k < 2; k++) begin
      drv32(1, 1, 1, SZ_W, 0, 0, 0, 0, 0, 0, 1); tick32();
      drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);    tick32();
    end
    drv32(1, 1, 1, SZ_W, 0, 0, 0, 0, 0, 0, 1);
    #1; chk("lim_blocked", b32.mem_allowin_o, 0); chk("lim_cnt2", cnt32, 2); tick32();
    drv32(1, 1, 1, SZ_W, 0, 0, 0, 1, 32'hAAAA, 0, 1);
    #1; chk("lim_drop_cycle", b32.mem_allowin_o, 0); tick32();
    drv32(1, 1, 1, SZ_W, 0, 0, 0, 0, 0, 0, 1);
    #1; chk("lim_reopen", b32.mem_allowin_o, 1); tick32();
    drv32(0, 0, 0, 0, 0, 0, 0, 1, 32'hBBBB, 0, 1); tick32();
    drv32(0, 0, 0, 0, 0, 0, 0, 1, 32'hCCCC, 0, 1); tick32();
    drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);         tick32();

    // Flush in the same cycle as an owned response.
    drv32(1, 1, 1, SZ_W, 0, 0, 0, 0, 0, 0, 1); tick32();
    drv32(0, 0, 0, 0, 0, 0, 0, 1, 32'h3333, 1, 1);
    #1; chk("flown_valid", b32.mem_to_wb_valid_o, 0); tick32();
    drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1; chk("flown_cnt", cnt32, 0); tick32();

    // Reset asserted while a load is outstanding.
    drv32(1, 1, 1, SZ_W, 0, 0, 0, 0, 0, 0, 1); tick32();
    drv32(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1; chk("pre_rst_stall", b32.dr_stall_o, 1);
    rst_n = 0; tick32();
    rst_n = 1; tick32();

    // Randomised traffic; responses only issued when one is owed.
    for (int c = 0; c < 3000; c++) begin
      int owed;
      owed = m_orph + ((m_full && m_pend) ? 1 : 0);
      drv32(($urandom % 3) != 0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
            2'($urandom), $urandom, (owed > 0) && ($urandom % 3 == 0), $urandom,
            ($urandom % 12) == 0, ($urandom % 3) != 0);
      tick32();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
